// File: rtl/ifu_fetch_if.sv
// Bundle of every handshake and data signal between the instruction-fetch
// sequencer and its surroundings (instruction memory, redirect source, IF/ID).
//
// Handshake rule for every valid/ready pair in this bundle:
// a transfer happens on a rising clk edge where both valid and ready are 1.
// Valid may depend combinationally on inputs such as redirect_valid.
// Once a producer raises valid it keeps valid and its payload stable until the
// transfer happens. The one exception is a redirect, which may withdraw an
// unaccepted fetch request.
interface ifu_fetch_if #(
  parameter int XLEN = 32
);
  // redirect from later pipeline stages
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  // instruction memory request channel
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  // instruction memory response channel
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            imem_rsp_ready;
  // IF/ID side
  logic            id_ready;
  logic            if_valid;
  logic [XLEN-1:0] if_inst;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     fetch_cnt;
  // current sequencer state, for observation only
  logic [2:0]      dbg_state;

  // the fetch sequencer side
  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr, imem_rsp_ready,
    output if_valid, if_inst, if_pc, fetch_cnt, dbg_state
  );

  // memory, redirect source and IF/ID register side
  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr, imem_rsp_ready,
    input  if_valid, if_inst, if_pc, fetch_cnt, dbg_state
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer. It owns the fetch PC and keeps at most one
// memory request outstanding. It hands fetched words to IF/ID and applies
// redirects. A response that belongs to a request issued before a redirect
// is consumed and thrown away, so it never reaches IF/ID.
module ifu_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] START_PC = 32'h8000_0000
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DROP = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  logic [2:0]      state_q,     state_d;
  logic [XLEN-1:0] fetch_pc_q,  fetch_pc_d;
  logic            if_valid_q,  if_valid_d;
  logic [XLEN-1:0] if_inst_q,   if_inst_d;
  logic [XLEN-1:0] if_pc_q,     if_pc_d;
  logic [31:0]     fetch_cnt_q, fetch_cnt_d;

  logic [XLEN-1:0] redirect_target;
  logic            req_fire;
  logic            unused_redirect_lsbs;

  // Redirect targets are word aligned. The two low bits are simply dropped.
  assign redirect_target      = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  // A redirect withdraws the request in the same cycle, so a request never
  // fires for a PC that is about to be replaced.
  assign bus.imem_req_valid = (state_q == S_REQ) && !bus.redirect_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.imem_rsp_ready = (state_q == S_WAIT) || (state_q == S_DROP);
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign bus.if_valid  = if_valid_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.fetch_cnt = fetch_cnt_q;
  assign bus.dbg_state = state_q;

  // Next-state logic: sequencing, PC update, redirect handling and delivery.
  // In WAIT and DROP, imem_rsp_ready is 1, so imem_rsp_valid alone means the
  // response is consumed this cycle.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    if_valid_d  = if_valid_q;
    if_inst_d   = if_inst_q;
    if_pc_d     = if_pc_q;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (bus.redirect_valid) begin
          fetch_pc_d = redirect_target;
        end
      end
      S_REQ: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = redirect_target;
        end else if (req_fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          // The outstanding request is now stale. If its response is here it
          // is discarded now. Otherwise DROP waits for it and discards it.
          fetch_pc_d = redirect_target;
          state_d    = bus.imem_rsp_valid ? S_REQ : S_DROP;
        end else if (bus.imem_rsp_valid) begin
          if_inst_d  = bus.imem_rsp_data;
          if_pc_d    = fetch_pc_q;
          if_valid_d = 1'b1;
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          state_d    = S_HOLD;
        end
      end
      S_DROP: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = redirect_target;
        end
        if (bus.imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          // The held instruction is on the wrong path. Kill it without
          // counting it as delivered.
          if_valid_d = 1'b0;
          fetch_pc_d = redirect_target;
          state_d    = S_REQ;
        end else if (bus.id_ready) begin
          if_valid_d  = 1'b0;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= START_PC;
      if_valid_q  <= 1'b0;
      if_inst_q   <= '0;
      if_pc_q     <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      if_valid_q  <= if_valid_d;
      if_inst_q   <= if_inst_d;
      if_pc_q     <= if_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Instruction-fetch sequencer feeding the IF/ID pipeline register.
- Owns the fetch PC and issues one request at a time to instruction memory over a valid/ready request channel plus a response channel.
- Presents the fetched instruction and its PC to IF/ID under a valid/ready handshake.
- Handles redirects (branch, jump, trap) from later stages, including discarding a response already in flight.

Parameters:
- START_PC, 32'h8000_0000, fetch PC after reset.
- XLEN, 32, width of PC and instruction.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- redirect_valid  in  1  a later stage requests a PC change this cycle.
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored and treated as 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  fetch address; always equals the fetch PC register.
- imem_rsp_valid  in  1  response valid.
- imem_rsp_data  in  XLEN  fetched instruction word.
- imem_rsp_ready  out  1  controller accepts the response.
- id_ready  in  1  IF/ID accepts the instruction this cycle.
- if_valid  out  1  if_inst/if_pc hold a valid instruction.
- if_inst  out  XLEN  instruction to IF/ID.
- if_pc  out  XLEN  PC of if_inst.
- fetch_cnt  out  32  count of instructions delivered to IF/ID; wraps at 2^32.

Behaviour:
- State machine states: IDLE, REQ, WAIT, DROP, HOLD. fetch_pc, if_valid, if_inst, if_pc and fetch_cnt are registers.
- Reset values:
  - state=IDLE, fetch_pc=START_PC.
  - if_valid=0, if_inst=0, if_pc=0, fetch_cnt=0.
  - imem_req_valid=0, imem_rsp_ready=0.
- Reset mid-operation: any in-flight response arriving after reset is ignored, because IDLE does not assert imem_rsp_ready.
- Combinational outputs:
  - imem_req_valid = (state==REQ) & ~redirect_valid.
  - imem_rsp_ready = (state==WAIT) | (state==DROP).
- Request/response handshake:
  - A request fires when imem_req_valid & imem_req_ready.
  - A response is consumed when imem_rsp_valid & imem_rsp_ready.
  - Memory returns the response no earlier than the cycle after the request fires.
- IDLE: next cycle goes to REQ unconditionally. A redirect in IDLE only loads fetch_pc.
- REQ:
  - redirect → fetch_pc=redirect_pc, stay REQ. No request fires that cycle.
  - Request fires → WAIT.
  - Otherwise hold the request; imem_req_addr stays stable.
- WAIT:
  - redirect (with or without a same-cycle response):
    - fetch_pc=redirect_pc.
    - Same-cycle response is discarded and state → REQ.
    - No response that cycle → DROP.
  - Response without redirect:
    - if_inst=imem_rsp_data, if_pc=fetch_pc, if_valid=1.
    - fetch_pc=fetch_pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0).
    - State → HOLD.
- DROP:
  - Response → discard it, state → REQ.
  - redirect → fetch_pc=redirect_pc. If a response arrives the same cycle, still → REQ; otherwise stay DROP.
- HOLD:
  - redirect (priority over id_ready) → if_valid=0, fetch_pc=redirect_pc, state → REQ. fetch_cnt is not incremented.
  - id_ready → if_valid=0, fetch_cnt+=1, state → REQ.
  - Otherwise hold if_inst, if_pc and if_valid unchanged.
- Latency and throughput:
  - Zero-wait memory (ready=1, response one cycle later): if_valid rises 2 cycles after entering REQ.
  - Steady-state throughput is one instruction per 3 cycles (REQ→WAIT→HOLD).
- At most one request outstanding at any time.
- A redirect never lets a stale instruction reach IF/ID: if_valid is 1 only for responses to requests issued after the last redirect.

Test Plan:
- Reset release, memory always ready, 1-cycle response returning 0x00000013:
  - First request address is 0x8000_0000.
  - if_valid=1 with if_pc=0x8000_0000, then 0x8000_0004, 0x8000_0008.
  - With id_ready=1, fetch_cnt=3 after three deliveries.
- Backpressure: id_ready=0 for 5 cycles in HOLD:
  - if_valid, if_inst and if_pc stay stable and no new request is issued.
  - Raising id_ready gives one increment of fetch_cnt.
- Redirect to 0x8000_0100 while in WAIT, response arriving 3 cycles later with 0xDEADBEEF:
  - That response is dropped and never appears on if_inst.
  - Next request address is 0x8000_0100.
- Redirect to 0x8000_0201 in the same cycle as the response in WAIT:
  - Response discarded; next request address is 0x8000_0200.
- Redirect in HOLD while id_ready=1:
  - if_valid=0 next cycle and fetch_cnt unchanged.
  - Next request is to the redirect target.
- PC wrap and counter wrap:
  - Redirect to 0xFFFF_FFFC, deliver two instructions → if_pc 0xFFFF_FFFC then 0x0000_0000.
  - Force fetch_cnt to 0xFFFF_FFFF (via hierarchical force) and accept one instruction → fetch_cnt=0.
- Reset asserted while in WAIT, stale response arriving afterwards:
  - Ignored; state and outputs return to reset values.
  - First request after reset is to START_PC.
